// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types for the unified memory-port arbiter and its benches.
//   arb_state_e : FSM encoding (IDLE -> REQ -> WAIT -> IDLE)
//   owner_e     : which requester owns the outstanding transaction
//   NOP         : RV32I canonical no-op (addi x0,x0,0), handy as filler data
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the data port and the memory port of the arbiter.
//   master : arbiter view (accepts requester traffic, drives the memory port)
//   slave  : environment view (fetch stage, data stage and memory model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // fetch requester
   logic            if_req_valid;
   logic [AW-1:0]   if_req_addr;
   logic            if_req_ready;
   logic            if_rsp_valid;
   logic [DW-1:0]   if_rsp_data;
   // data requester
   logic            d_req_valid;
   logic            d_req_we;
   logic [AW-1:0]   d_req_addr;
   logic [DW-1:0]   d_req_wdata;
   logic [DW/8-1:0] d_req_wstrb;
   logic            d_req_ready;
   logic            d_rsp_valid;
   logic [DW-1:0]   d_rsp_rdata;
   // memory
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_we;
   logic [AW-1:0]   mem_req_addr;
   logic [DW-1:0]   mem_req_wdata;
   logic [DW/8-1:0] mem_req_wstrb;
   logic            mem_rsp_valid;
   logic [DW-1:0]   mem_rsp_rdata;

   modport master (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
      output d_req_ready, d_rsp_valid, d_rsp_rdata,
      output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

   modport slave (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
      input  d_req_ready, d_rsp_valid, d_rsp_rdata,
      input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

endinterface

// File: rtl/mem_arb_priority.sv
// -----------------------------------------------------------------------------
// mem_arb_priority
// Combinational grant selection between fetch and data requesters.
//   en           : arbiter is idle and may grant this cycle
//   if_valid     : fetch request pending
//   d_valid      : data request pending
//   starve_cnt   : data grants made while fetch was waiting
//   grant_if/d   : one-hot grant (both 0 when nothing is granted)
//   starve_cnt_d : counter value to register if a grant happens
// -----------------------------------------------------------------------------
module mem_arb_priority #(
   parameter int STARVE_LIMIT = 4,
   parameter int CW           = $clog2(STARVE_LIMIT + 1)
) (
   input  logic          en,
   input  logic          if_valid,
   input  logic          d_valid,
   input  logic [CW-1:0] starve_cnt,
   output logic          grant_if,
   output logic          grant_d,
   output logic [CW-1:0] starve_cnt_d
);

   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves
      // a value unassigned and no latch is inferred.
      grant_if     = 1'b0;
      grant_d      = 1'b0;
      starve_cnt_d = starve_cnt;
      if (en) begin
         // Data normally wins; a starved fetch overrides it once.
         if (if_valid && (!d_valid || (starve_cnt == LIMIT))) begin
            grant_if     = 1'b1;
            starve_cnt_d = '0;
         end else if (d_valid) begin
            grant_d = 1'b1;
            // Only data grants that actually made fetch wait count as starvation.
            if (if_valid && (starve_cnt != LIMIT)) begin
               starve_cnt_d = starve_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch and load/store, one
// transaction outstanding at a time. Stale fetch responses after a redirect
// flush are consumed silently.
//   clk   : clock
//   reset : synchronous, active-high reset
//   flush : fetch redirect; marks an accepted, unfinished fetch as stale
//   bus   : fetch / data / memory handshakes (master view)
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int AW           = 32,
   parameter int DW           = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   mem_port_arbiter_if.master  bus
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   arb_state_e      state_q;
   owner_e          owner_q;
   logic            drop_q;
   logic [CW-1:0]   starve_q;
   logic [CW-1:0]   starve_d;
   logic            mem_req_valid_q;
   logic            mem_req_we_q;
   logic [AW-1:0]   mem_req_addr_q;
   logic [DW-1:0]   mem_req_wdata_q;
   logic [DW/8-1:0] mem_req_wstrb_q;

   logic arb_en;
   logic grant_if;
   logic grant_d;
   logic rsp_fire;

   // Grants are only offered while idle; reset keeps all outputs low.
   assign arb_en = (state_q == ST_IDLE) && !reset;

   mem_arb_priority #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_priority (
      .en           (arb_en),
      .if_valid     (bus.if_req_valid),
      .d_valid      (bus.d_req_valid),
      .starve_cnt   (starve_q),
      .grant_if     (grant_if),
      .grant_d      (grant_d),
      .starve_cnt_d (starve_d)
   );

   // NOTE: all state here is written with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         owner_q         <= OWN_NONE;
         drop_q          <= 1'b0;
         starve_q        <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_we_q    <= 1'b0;
         mem_req_addr_q  <= '0;
         mem_req_wdata_q <= '0;
         mem_req_wstrb_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_if || grant_d) begin
                  state_q         <= ST_REQ;
                  mem_req_valid_q <= 1'b1;
                  starve_q        <= starve_d;
                  if (grant_d) begin
                     owner_q         <= OWN_DATA;
                     drop_q          <= 1'b0;
                     mem_req_we_q    <= bus.d_req_we;
                     mem_req_addr_q  <= bus.d_req_addr;
                     mem_req_wdata_q <= bus.d_req_wdata;
                     mem_req_wstrb_q <= bus.d_req_wstrb;
                  end else begin
                     owner_q         <= OWN_IF;
                     // A redirect in the grant cycle already makes this fetch stale.
                     drop_q          <= flush;
                     mem_req_we_q    <= 1'b0;
                     mem_req_addr_q  <= bus.if_req_addr;
                     mem_req_wdata_q <= '0;
                     mem_req_wstrb_q <= '0;
                  end
               end
            end
            ST_REQ: begin
               if (flush && (owner_q == OWN_IF)) drop_q <= 1'b1;
               // The request is never withdrawn; a flushed fetch still finishes.
               if (bus.mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (flush && (owner_q == OWN_IF)) drop_q <= 1'b1;
               if (bus.mem_rsp_valid) begin
                  state_q <= ST_IDLE;
                  owner_q <= OWN_NONE;
                  drop_q  <= 1'b0;
               end
            end
            default: begin
               state_q         <= ST_IDLE;
               owner_q         <= OWN_NONE;
               drop_q          <= 1'b0;
               mem_req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Responses arriving outside WAIT are protocol violations and are ignored.
   assign rsp_fire = (state_q == ST_WAIT) && bus.mem_rsp_valid && !reset;

   assign bus.if_req_ready = grant_if;
   assign bus.d_req_ready  = grant_d;

   assign bus.d_rsp_valid  = rsp_fire && (owner_q == OWN_DATA);
   assign bus.d_rsp_rdata  = bus.d_rsp_valid ? bus.mem_rsp_rdata : '0;
   assign bus.if_rsp_valid = rsp_fire && (owner_q == OWN_IF) && !drop_q;
   assign bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rsp_rdata : '0;

   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_req_we    = mem_req_we_q;
   assign bus.mem_req_addr  = mem_req_addr_q;
   assign bus.mem_req_wdata = mem_req_wdata_q;
   assign bus.mem_req_wstrb = mem_req_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: fetch-only, data priority, starvation
// override, redirect flush, stalled store, reset mid-transaction.
// Inputs change 1 ns after the falling edge; outputs are sampled shortly after.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW           = 32;
   localparam int DW           = 32;
   localparam int STARVE_LIMIT = 4;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .AW           (AW),
      .DW           (DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus.master)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.if_req_valid  = 1'b0;
      bus.if_req_addr   = '0;
      bus.d_req_valid   = 1'b0;
      bus.d_req_we      = 1'b0;
      bus.d_req_addr    = '0;
      bus.d_req_wdata   = '0;
      bus.d_req_wstrb   = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
   endtask

   // Memory model: waits (bounded) for a request, accepts it after acc_wait
   // stall cycles, then responds rsp_wait cycles later. Returns with the
   // response being driven so the caller can check routing.
   task automatic mem_serve(input int acc_wait, input int rsp_wait, input logic [31:0] rdata);
      int n;
      n = 0;
      while (!bus.mem_req_valid && n < 20) begin
         cyc();
         n++;
      end
      check("mem_req_valid_seen", bus.mem_req_valid, 1'b1);
      repeat (acc_wait) cyc();
      bus.mem_req_ready = 1'b1;
      cyc();
      bus.mem_req_ready = 1'b0;
      repeat (rsp_wait) cyc();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = rdata;
      #1;
      // A memory response is only legal while the arbiter waits for one.
      check("rsp_only_in_wait", dut.state_q, ST_WAIT);
   endtask

   task automatic rsp_done();
      cyc();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic       exp_d  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [2:0] exp_cnt[6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

   initial begin
      clear_inputs();
      flush = 1'b0;
      reset = 1'b1;

      // ---------------- reset state ----------------
      cyc();
      bus.if_req_valid = 1'b1;
      #1;
      check("rst_if_req_ready", bus.if_req_ready, 1'b0);
      check("rst_d_req_ready", bus.d_req_ready, 1'b0);
      check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      check("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
      check("rst_state", dut.state_q, ST_IDLE);
      check("rst_starve", dut.starve_q, 3'd0);
      bus.if_req_valid = 1'b0;
      cyc();
      reset = 1'b0;

      // ---------------- 1: fetch only ----------------
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h0;
      #1;
      check("t1_if_req_ready", bus.if_req_ready, 1'b1);
      check("t1_d_req_ready", bus.d_req_ready, 1'b0);
      cyc();
      bus.if_req_valid = 1'b0;
      bus.if_req_addr  = 32'hFFFF_FFFF;
      #1;
      check("t1_mem_req_valid_T1", bus.mem_req_valid, 1'b1);
      check("t1_mem_req_addr", bus.mem_req_addr, 32'h0);
      check("t1_mem_req_we", bus.mem_req_we, 1'b0);
      mem_serve(0, 1, 32'h0050_0093);
      check("t1_if_rsp_valid", bus.if_rsp_valid, 1'b1);
      check("t1_if_rsp_data", bus.if_rsp_data, 32'h0050_0093);
      check("t1_d_rsp_valid", bus.d_rsp_valid, 1'b0);
      rsp_done();
      check("t1_if_rsp_pulse", bus.if_rsp_valid, 1'b0);

      // ---------------- 2: simultaneous requests ----------------
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h4;
      bus.d_req_valid  = 1'b1;
      bus.d_req_addr   = 32'h100;
      #1;
      check("t2_d_req_ready", bus.d_req_ready, 1'b1);
      check("t2_if_req_ready", bus.if_req_ready, 1'b0);
      cyc();
      bus.d_req_valid = 1'b0;
      #1;
      check("t2_starve_1", dut.starve_q, 3'd1);
      check("t2_mem_addr_data", bus.mem_req_addr, 32'h100);
      check("t2_if_blocked", bus.if_req_ready, 1'b0);
      mem_serve(0, 1, 32'hCAFE_0001);
      check("t2_d_rsp_valid", bus.d_rsp_valid, 1'b1);
      check("t2_d_rsp_rdata", bus.d_rsp_rdata, 32'hCAFE_0001);
      check("t2_if_rsp_valid", bus.if_rsp_valid, 1'b0);
      rsp_done();
      check("t2_if_granted_after", bus.if_req_ready, 1'b1);
      cyc();
      bus.if_req_valid = 1'b0;
      #1;
      check("t2_starve_0", dut.starve_q, 3'd0);
      check("t2_mem_addr_fetch", bus.mem_req_addr, 32'h4);
      mem_serve(0, 0, NOP);
      check("t2_if_rsp_data", bus.if_rsp_data, NOP);
      rsp_done();

      // ---------------- 3: starvation override ----------------
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'hC;
      bus.d_req_valid  = 1'b1;
      bus.d_req_addr   = 32'h300;
      #1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t3_d_ready_%0d", i), bus.d_req_ready, exp_d[i]);
         check($sformatf("t3_if_ready_%0d", i), bus.if_req_ready, !exp_d[i]);
         cyc();
         check($sformatf("t3_starve_%0d", i), dut.starve_q, exp_cnt[i]);
         check($sformatf("t3_addr_%0d", i), bus.mem_req_addr, exp_d[i] ? 32'h300 : 32'hC);
         mem_serve(0, 0, 32'h1000 + i);
         check($sformatf("t3_d_rsp_%0d", i), bus.d_rsp_valid, exp_d[i]);
         check($sformatf("t3_if_rsp_%0d", i), bus.if_rsp_valid, !exp_d[i]);
         rsp_done();
      end
      bus.if_req_valid = 1'b0;
      bus.d_req_valid  = 1'b0;
      #1;

      // ---------------- 4: flush ----------------
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h8;
      #1;
      check("t4_if_req_ready", bus.if_req_ready, 1'b1);
      cyc();
      bus.if_req_valid = 1'b0;
      #1;
      check("t4_mem_addr", bus.mem_req_addr, 32'h8);
      bus.mem_req_ready = 1'b1;
      cyc();
      bus.mem_req_ready = 1'b0;
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      #1;
      check("t4_drop_set", dut.drop_q, 1'b1);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'hDEAD_BEEF;
      #1;
      check("t4_if_rsp_dropped", bus.if_rsp_valid, 1'b0);
      check("t4_if_rsp_data_zero", bus.if_rsp_data, 32'h0);
      check("t4_d_rsp_valid", bus.d_rsp_valid, 1'b0);
      rsp_done();
      check("t4_drop_clear", dut.drop_q, 1'b0);
      check("t4_state_idle", dut.state_q, ST_IDLE);
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h40;
      #1;
      check("t4_next_if_ready", bus.if_req_ready, 1'b1);
      cyc();
      bus.if_req_valid = 1'b0;
      #1;
      check("t4_next_addr", bus.mem_req_addr, 32'h40);
      mem_serve(0, 1, 32'h00A0_0113);
      check("t4_next_if_rsp_valid", bus.if_rsp_valid, 1'b1);
      check("t4_next_if_rsp_data", bus.if_rsp_data, 32'h00A0_0113);
      rsp_done();
      // Flush in the grant cycle itself.
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h80;
      flush            = 1'b1;
      #1;
      cyc();
      bus.if_req_valid = 1'b0;
      flush            = 1'b0;
      mem_serve(0, 0, NOP);
      check("t4_grant_flush_dropped", bus.if_rsp_valid, 1'b0);
      rsp_done();

      // ---------------- 5: stalled store ----------------
      bus.d_req_valid = 1'b1;
      bus.d_req_we    = 1'b1;
      bus.d_req_addr  = 32'h200;
      bus.d_req_wdata = 32'h1234_5678;
      bus.d_req_wstrb = 4'hF;
      #1;
      check("t5_d_req_ready", bus.d_req_ready, 1'b1);
      cyc();
      bus.d_req_valid = 1'b0;
      bus.d_req_we    = 1'b0;
      bus.d_req_addr  = 32'h0;
      bus.d_req_wdata = 32'h0;
      bus.d_req_wstrb = 4'h0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t5_valid_%0d", k), bus.mem_req_valid, 1'b1);
         check($sformatf("t5_we_%0d", k), bus.mem_req_we, 1'b1);
         check($sformatf("t5_addr_%0d", k), bus.mem_req_addr, 32'h200);
         check($sformatf("t5_wdata_%0d", k), bus.mem_req_wdata, 32'h1234_5678);
         check($sformatf("t5_wstrb_%0d", k), bus.mem_req_wstrb, 4'hF);
         cyc();
      end
      bus.mem_req_ready = 1'b1;
      cyc();
      bus.mem_req_ready = 1'b0;
      #1;
      check("t5_valid_dropped", bus.mem_req_valid, 1'b0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      #1;
      check("t5_flush_no_effect", dut.drop_q, 1'b0);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h0;
      #1;
      check("t5_d_rsp_valid", bus.d_rsp_valid, 1'b1);
      check("t5_if_rsp_valid", bus.if_rsp_valid, 1'b0);
      rsp_done();
      check("t5_d_rsp_pulse", bus.d_rsp_valid, 1'b0);

      // ---------------- 6: reset during WAIT ----------------
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h10;
      #1;
      cyc();
      bus.if_req_valid  = 1'b0;
      bus.mem_req_ready = 1'b1;
      cyc();
      bus.mem_req_ready = 1'b0;
      #1;
      check("t6_in_wait", dut.state_q, ST_WAIT);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      check("t6_state_idle", dut.state_q, ST_IDLE);
      check("t6_mem_req_valid", bus.mem_req_valid, 1'b0);
      check("t6_owner_none", dut.owner_q, OWN_NONE);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h1111_1111;
      #1;
      check("t6_stray_if_rsp", bus.if_rsp_valid, 1'b0);
      check("t6_stray_d_rsp", bus.d_rsp_valid, 1'b0);
      cyc();
      bus.mem_rsp_valid = 1'b0;
      #1;
      check("t6_still_idle", dut.state_q, ST_IDLE);
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h14;
      #1;
      check("t6_next_if_ready", bus.if_req_ready, 1'b1);
      cyc();
      bus.if_req_valid = 1'b0;
      #1;
      check("t6_next_addr", bus.mem_req_addr, 32'h14);
      mem_serve(1, 0, NOP);
      check("t6_next_if_rsp_valid", bus.if_rsp_valid, 1'b1);
      check("t6_next_if_rsp_data", bus.if_rsp_data, NOP);
      rsp_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
